branch_predict_mux: RTL and testbench
=====================================

Name: branch_predict_mux

Overview:
- Parametrised ID-stage decode/redirect block: operand and register-index muxing between ID and id_ex_reg.
- Adds a dynamic branch predictor: a branch history table (BHT) of 2-bit saturating counters, read by PC in IF and trained on branch resolution in ID.
- Issues taken/not-taken redirects only on misprediction, plus unconditional jump overloads.
- Keeps wrap-around branch and mispredict statistics counters for the debug/UART readout path.

Parameters:
- ISA_WIDTH, 32: datapath and PC width.
- ADDRESS_WIDTH, 26: J-type target field width.
- SHIFT_AMOUNT_WIDTH, 5: shamt width.
- REG_FILE_ADDR_WIDTH, 5: register index width.
- BHT_INDEX_WIDTH, 6: BHT has 2^BHT_INDEX_WIDTH entries.
- BHT_INIT, 2'b01: counter reset value (weakly not-taken).
- JAL_REG_IDX, 31: link register index.
- STAT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  ISA_WIDTH  PC of the instruction being fetched.
- if_predict_taken  out  1  prediction for if_pc, to instruction_mem and if_id_reg.
- id_predicted_taken  in  1  prediction carried with the ID instruction, from if_id_reg.
- id_stall  in  1  hazard stall; the ID instruction is held and must not train the BHT.
- id_no_op  in  1  ID slot is a bubble.
- i_type_instruction, r_type_instruction, j_instruction, jr_instruction, jal_instruction, branch_instruction, shift_instruction  in  1 each  decode flags from control_unit.
- condition_satisfied  in  1  branch outcome from condition_check.
- id_pc, id_instruction, id_reg_1, id_reg_2, id_sign_extend_result  in  ISA_WIDTH each  ID-stage values.
- shift_amount  in  SHIFT_AMOUNT_WIDTH  shamt field.
- id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx  in  REG_FILE_ADDR_WIDTH each  register fields.
- pc_offset  out  1  branch taken but predicted not-taken; redirect to id_pc + offset.
- pc_restore  out  1  branch predicted taken but not taken; redirect to pc_restore_value.
- pc_restore_value  out  ISA_WIDTH  id_pc + ISA_WIDTH/8.
- pc_overload  out  1  jump redirect.
- pc_overload_value  out  ISA_WIDTH  jump target.
- mux_operand_1, mux_operand_2  out  ISA_WIDTH each  ALU operands.
- mux_reg_1_idx, mux_reg_2_idx, mux_reg_dest_idx  out  REG_FILE_ADDR_WIDTH each  forwarding and writeback indices.
- branch_count, mispredict_count  out  STAT_WIDTH each  statistics.

Behaviour:
- Reset (async, takes effect immediately on rst high): every BHT entry = BHT_INIT; branch_count = mispredict_count = 0; if_predict_taken forced to 0 while rst is high.
- BHT index is pc[BHT_INDEX_WIDTH+1:2]: if_pc for lookup, id_pc for update.
- Lookup is combinational: if_predict_taken = counter[1] of the selected entry.
- Training event: train = ~id_no_op & branch_instruction & ~id_stall, applied at the rising edge.
  - Taken: counter increments, saturating at 3.
  - Not taken: counter decrements, saturating at 0.
- Same-index read/update in one cycle: lookup returns the pre-update value; the new value is visible the next cycle.
- Redirects (combinational; all forced 0 when id_no_op = 1):
  - pc_offset = branch & cond & ~id_predicted_taken.
  - pc_restore = branch & ~cond & id_predicted_taken.
  - pc_overload = j | jal | jr.
  - A correctly predicted branch produces no redirect.
  - At most one redirect is high in any cycle.
- pc_overload_value:
  - j/jal: {id_pc[ISA_WIDTH-1:ADDRESS_WIDTH+2], id_instruction[ADDRESS_WIDTH-1:0], 2'b00}.
  - jr: id_reg_1.
- Operand mux:
  - mux_operand_1 = id_pc for jal; zero-extended shamt for shift; else id_reg_1.
  - mux_operand_2 = id_sign_extend_result for I-type; ISA_WIDTH/8 for jal; else id_reg_2.
- Index mux:
  - mux_reg_1_idx = 0 for j/jal/shift; else id_reg_1_idx.
  - mux_reg_2_idx = id_reg_2_idx for R-type or branch; else 0.
  - mux_reg_dest_idx priority: I-type → id_reg_2_idx; branch/jr → 0; jal → JAL_REG_IDX; else id_reg_dest_idx.
- Statistics:
  - branch_count increments on every train.
  - mispredict_count increments on every train where pc_offset | pc_restore.
  - Both wrap modulo 2^STAT_WIDTH.
- Stall: while id_stall is high, redirects still reflect the held instruction, but the BHT and counters are frozen. The instruction trains exactly once, in the cycle id_stall drops.
- Reset mid-operation: an edge coinciding with rst is ignored; state stays at reset values.

Test Plan:
- Reset, then if_pc = 0x0040_0010 → if_predict_taken = 0; both counters 0; every BHT entry reads 2'b01 when swept.
- Branch at id_pc = 0x0040_0010, id_predicted_taken = 0, cond = 1 → pc_offset = 1, pc_restore = 0; next cycle lookup at 0x0040_0010 gives 1; branch_count = 1, mispredict_count = 1.
- Same branch taken 4 more times (correctly predicted) → no redirects, counter saturates at 3; one not-taken with id_predicted_taken = 1 → pc_restore = 1, pc_restore_value = 0x0040_0014, counter = 2, prediction still 1.
- Train the entry for id_pc = 0x0040_0010 while if_pc = 0x0040_0110 (same index 4, BHT_INDEX_WIDTH = 6) → if_predict_taken shows the old value that cycle and the new value the next.
- id_stall = 1 for 3 cycles with a taken branch → counters unchanged; on release both increment by exactly 1. Also: id_no_op = 1 with jal → pc_overload = 0.
- jal at id_pc = 0x0040_0020, target field 0x0100008 → pc_overload_value = 0x0040_0020, mux_operand_2 = 4, mux_reg_dest_idx = 31. mispredict_count preloaded to 0xFFFF, then a mispredict → wraps to 0.

Source files
------------

// File: rtl/branch_predict_mux.sv
// ID-stage operand/index mux and redirect logic with a BHT-based dynamic
// branch predictor and wrap-around branch/mispredict statistics.
module branch_predict_mux #(
  parameter int          ISA_WIDTH           = 32,
  parameter int          ADDRESS_WIDTH       = 26,
  parameter int          SHIFT_AMOUNT_WIDTH  = 5,
  parameter int          REG_FILE_ADDR_WIDTH = 5,
  parameter int          BHT_INDEX_WIDTH     = 6,
  parameter logic [1:0]  BHT_INIT            = 2'b01,
  parameter int          JAL_REG_IDX         = 31,
  parameter int          STAT_WIDTH          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ISA_WIDTH-1:0]           if_pc,
  output logic                           if_predict_taken,
  input  logic                           id_predicted_taken,
  input  logic                           id_stall,
  input  logic                           id_no_op,
  input  logic                           i_type_instruction,
  input  logic                           r_type_instruction,
  input  logic                           j_instruction,
  input  logic                           jr_instruction,
  input  logic                           jal_instruction,
  input  logic                           branch_instruction,
  input  logic                           shift_instruction,
  input  logic                           condition_satisfied,
  input  logic [ISA_WIDTH-1:0]           id_pc,
  input  logic [ISA_WIDTH-1:0]           id_instruction,
  input  logic [ISA_WIDTH-1:0]           id_reg_1,
  input  logic [ISA_WIDTH-1:0]           id_reg_2,
  input  logic [ISA_WIDTH-1:0]           id_sign_extend_result,
  input  logic [SHIFT_AMOUNT_WIDTH-1:0]  shift_amount,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] id_reg_1_idx,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] id_reg_2_idx,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] id_reg_dest_idx,
  output logic                           pc_offset,
  output logic                           pc_restore,
  output logic [ISA_WIDTH-1:0]           pc_restore_value,
  output logic                           pc_overload,
  output logic [ISA_WIDTH-1:0]           pc_overload_value,
  output logic [ISA_WIDTH-1:0]           mux_operand_1,
  output logic [ISA_WIDTH-1:0]           mux_operand_2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] mux_reg_1_idx,
  output logic [REG_FILE_ADDR_WIDTH-1:0] mux_reg_2_idx,
  output logic [REG_FILE_ADDR_WIDTH-1:0] mux_reg_dest_idx,
  output logic [STAT_WIDTH-1:0]          branch_count,
  output logic [STAT_WIDTH-1:0]          mispredict_count
);

  localparam int unsigned BHT_SIZE = 2 ** BHT_INDEX_WIDTH;
  localparam logic [ISA_WIDTH-1:0] INSTR_BYTES = ISA_WIDTH'(ISA_WIDTH / 8);

  logic [1:0]                 bht [BHT_SIZE];
  logic [BHT_INDEX_WIDTH-1:0] lookup_idx;
  logic [BHT_INDEX_WIDTH-1:0] update_idx;
  logic [1:0]                 cur_ctr;
  logic [1:0]                 next_ctr;
  logic                       train;
  logic                       unused_bits;

  assign lookup_idx = if_pc[BHT_INDEX_WIDTH+1:2];
  assign update_idx = id_pc[BHT_INDEX_WIDTH+1:2];
  assign train      = ~id_no_op & branch_instruction & ~id_stall;
  assign unused_bits = ^{if_pc[1:0], if_pc[ISA_WIDTH-1:BHT_INDEX_WIDTH+2],
                         id_instruction[ISA_WIDTH-1:ADDRESS_WIDTH]};

  // Combinational lookup; reads the pre-update counter on a same-index train
  always_comb begin
    if_predict_taken = 1'b0;
    if (!rst) if_predict_taken = bht[lookup_idx][1];
  end

  // Saturating 2-bit counter update for the resolving branch
  always_comb begin
    cur_ctr  = bht[update_idx];
    next_ctr = cur_ctr;
    if (condition_satisfied) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
    end
  end

  // BHT storage: reset every entry to the init value, train on resolution
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_SIZE; i++) bht[i] <= BHT_INIT;
    end else if (train) begin
      bht[update_idx] <= next_ctr;
    end
  end

  // Redirect generation; only mispredicted branches and jumps redirect
  always_comb begin
    pc_offset   = 1'b0;
    pc_restore  = 1'b0;
    pc_overload = 1'b0;
    if (!id_no_op) begin
      pc_offset   = branch_instruction & condition_satisfied & ~id_predicted_taken;
      pc_restore  = branch_instruction & ~condition_satisfied & id_predicted_taken;
      pc_overload = j_instruction | jal_instruction | jr_instruction;
    end
  end

  assign pc_restore_value = id_pc + INSTR_BYTES;

  // Jump target: register for jr, pseudo-direct region address for j/jal
  always_comb begin
    pc_overload_value = {id_pc[ISA_WIDTH-1:ADDRESS_WIDTH+2],
                         id_instruction[ADDRESS_WIDTH-1:0], 2'b00};
    if (jr_instruction) pc_overload_value = id_reg_1;
  end

  // ALU operand selection
  always_comb begin
    mux_operand_1 = id_reg_1;
    if (jal_instruction)
      mux_operand_1 = id_pc;
    else if (shift_instruction)
      mux_operand_1 = {{(ISA_WIDTH-SHIFT_AMOUNT_WIDTH){1'b0}}, shift_amount};
    mux_operand_2 = id_reg_2;
    if (i_type_instruction)
      mux_operand_2 = id_sign_extend_result;
    else if (jal_instruction)
      mux_operand_2 = INSTR_BYTES;
  end

  // Register index selection for forwarding and writeback
  always_comb begin
    mux_reg_1_idx = id_reg_1_idx;
    if (j_instruction | jal_instruction | shift_instruction) mux_reg_1_idx = '0;
    mux_reg_2_idx = '0;
    if (r_type_instruction | branch_instruction) mux_reg_2_idx = id_reg_2_idx;
    if (i_type_instruction)
      mux_reg_dest_idx = id_reg_2_idx;
    else if (branch_instruction | jr_instruction)
      mux_reg_dest_idx = '0;
    else if (jal_instruction)
      mux_reg_dest_idx = REG_FILE_ADDR_WIDTH'(JAL_REG_IDX);
    else
      mux_reg_dest_idx = id_reg_dest_idx;
  end

  // Wrap-around statistics, frozen with the BHT during stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      branch_count <= branch_count + 1'b1;
      if (pc_offset | pc_restore) mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_mux.sv
// Directed self-checking bench for branch_predict_mux.
module tb_branch_predict_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_predict_taken;
  logic        id_predicted_taken, id_stall, id_no_op;
  logic        i_type_instruction, r_type_instruction, j_instruction;
  logic        jr_instruction, jal_instruction, branch_instruction, shift_instruction;
  logic        condition_satisfied;
  logic [31:0] id_pc, id_instruction, id_reg_1, id_reg_2, id_sign_extend_result;
  logic [4:0]  shift_amount, id_reg_1_idx, id_reg_2_idx, id_reg_dest_idx;
  logic        pc_offset, pc_restore, pc_overload;
  logic [31:0] pc_restore_value, pc_overload_value, mux_operand_1, mux_operand_2;
  logic [4:0]  mux_reg_1_idx, mux_reg_2_idx, mux_reg_dest_idx;
  logic [15:0] branch_count, mispredict_count;

  int compared = 0;
  int mismatched = 0;

  branch_predict_mux #(
    .ISA_WIDTH(32), .ADDRESS_WIDTH(26), .SHIFT_AMOUNT_WIDTH(5),
    .REG_FILE_ADDR_WIDTH(5), .BHT_INDEX_WIDTH(6), .BHT_INIT(2'b01),
    .JAL_REG_IDX(31), .STAT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_predict_taken(if_predict_taken),
    .id_predicted_taken(id_predicted_taken), .id_stall(id_stall), .id_no_op(id_no_op),
    .i_type_instruction(i_type_instruction), .r_type_instruction(r_type_instruction),
    .j_instruction(j_instruction), .jr_instruction(jr_instruction),
    .jal_instruction(jal_instruction), .branch_instruction(branch_instruction),
    .shift_instruction(shift_instruction), .condition_satisfied(condition_satisfied),
    .id_pc(id_pc), .id_instruction(id_instruction), .id_reg_1(id_reg_1),
    .id_reg_2(id_reg_2), .id_sign_extend_result(id_sign_extend_result),
    .shift_amount(shift_amount), .id_reg_1_idx(id_reg_1_idx),
    .id_reg_2_idx(id_reg_2_idx), .id_reg_dest_idx(id_reg_dest_idx),
    .pc_offset(pc_offset), .pc_restore(pc_restore), .pc_restore_value(pc_restore_value),
    .pc_overload(pc_overload), .pc_overload_value(pc_overload_value),
    .mux_operand_1(mux_operand_1), .mux_operand_2(mux_operand_2),
    .mux_reg_1_idx(mux_reg_1_idx), .mux_reg_2_idx(mux_reg_2_idx),
    .mux_reg_dest_idx(mux_reg_dest_idx), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then leave 1 time unit for the DUT to settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_predicted_taken = 0; id_stall = 0; id_no_op = 0;
    i_type_instruction = 0; r_type_instruction = 0; j_instruction = 0;
    jr_instruction = 0; jal_instruction = 0; branch_instruction = 0;
    shift_instruction = 0; condition_satisfied = 0;
  endtask

  task automatic test_reset();
    idle();
    if_pc = 32'h0040_0010; id_pc = 32'h0040_0010; id_instruction = '0;
    id_reg_1 = '0; id_reg_2 = '0; id_sign_extend_result = '0; shift_amount = '0;
    id_reg_1_idx = '0; id_reg_2_idx = '0; id_reg_dest_idx = '0;
    rst = 1;
    #1;
    compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL reset_pred_during_rst got=%b exp=0", if_predict_taken); end
    tick(); tick();
    rst = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL reset_pred got=%b exp=0", if_predict_taken); end
    compared++; if (branch_count !== 16'd0) begin mismatched++; $display("FAIL reset_branch_count got=%0d exp=0", branch_count); end
    compared++; if (mispredict_count !== 16'd0) begin mismatched++; $display("FAIL reset_mispredict_count got=%0d exp=0", mispredict_count); end
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL reset_sweep idx=%0d got=%b exp=0", i, if_predict_taken); end
    end
  endtask

  task automatic test_offset();
    if_pc = 32'h0040_0010; id_pc = 32'h0040_0010;
    branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 0;
    #1;
    compared++; if (pc_offset !== 1'b1) begin mismatched++; $display("FAIL offset_pc_offset got=%b exp=1", pc_offset); end
    compared++; if (pc_restore !== 1'b0) begin mismatched++; $display("FAIL offset_pc_restore got=%b exp=0", pc_restore); end
    compared++; if (pc_overload !== 1'b0) begin mismatched++; $display("FAIL offset_pc_overload got=%b exp=0", pc_overload); end
    compared++; if (mux_reg_dest_idx !== 5'd0) begin mismatched++; $display("FAIL offset_branch_dest got=%0d exp=0", mux_reg_dest_idx); end
    tick();
    branch_instruction = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b1) begin mismatched++; $display("FAIL offset_pred_after got=%b exp=1", if_predict_taken); end
    compared++; if (branch_count !== 16'd1) begin mismatched++; $display("FAIL offset_branch_count got=%0d exp=1", branch_count); end
    compared++; if (mispredict_count !== 16'd1) begin mismatched++; $display("FAIL offset_mispredict_count got=%0d exp=1", mispredict_count); end
  endtask

  // Counter 2 -> 3 (saturated), then two not-taken: 3 -> 2 (pred 1) -> 1 (pred 0)
  task automatic test_saturate_restore();
    branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      compared++; if ({pc_offset, pc_restore, pc_overload} !== 3'b000) begin mismatched++; $display("FAIL correct_pred_redirect k=%0d got=%b exp=000", k, {pc_offset, pc_restore, pc_overload}); end
      tick();
    end
    condition_satisfied = 0;
    #1;
    compared++; if (pc_restore !== 1'b1) begin mismatched++; $display("FAIL restore_flag got=%b exp=1", pc_restore); end
    compared++; if (pc_offset !== 1'b0) begin mismatched++; $display("FAIL restore_offset got=%b exp=0", pc_offset); end
    compared++; if (pc_restore_value !== 32'h0040_0014) begin mismatched++; $display("FAIL restore_value got=%h exp=00400014", pc_restore_value); end
    tick();
    compared++; if (if_predict_taken !== 1'b1) begin mismatched++; $display("FAIL sat_pred_ctr2 got=%b exp=1", if_predict_taken); end
    tick();
    branch_instruction = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL sat_pred_ctr1 got=%b exp=0", if_predict_taken); end
    compared++; if (branch_count !== 16'd7) begin mismatched++; $display("FAIL sat_branch_count got=%0d exp=7", branch_count); end
    compared++; if (mispredict_count !== 16'd3) begin mismatched++; $display("FAIL sat_mispredict_count got=%0d exp=3", mispredict_count); end
  endtask

  // Counter at index 4 is 1; lookup from an aliasing PC while it trains to 2
  task automatic test_same_index();
    if_pc = 32'h0040_0110; id_pc = 32'h0040_0010;
    branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL same_idx_old got=%b exp=0", if_predict_taken); end
    tick();
    branch_instruction = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b1) begin mismatched++; $display("FAIL same_idx_new got=%b exp=1", if_predict_taken); end
  endtask

  task automatic test_stall();
    id_pc = 32'h0040_0080; if_pc = 32'h0040_0080;
    branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 0; id_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      compared++; if (pc_offset !== 1'b1) begin mismatched++; $display("FAIL stall_redirect k=%0d got=%b exp=1", k, pc_offset); end
      tick();
      compared++; if (branch_count !== 16'd8 || mispredict_count !== 16'd4) begin mismatched++; $display("FAIL stall_frozen k=%0d got=%0d/%0d exp=8/4", k, branch_count, mispredict_count); end
      compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL stall_bht_frozen k=%0d got=%b exp=0", k, if_predict_taken); end
    end
    id_stall = 0;
    tick();
    branch_instruction = 0;
    tick();
    compared++; if (branch_count !== 16'd9 || mispredict_count !== 16'd5) begin mismatched++; $display("FAIL stall_release got=%0d/%0d exp=9/5", branch_count, mispredict_count); end
    compared++; if (if_predict_taken !== 1'b1) begin mismatched++; $display("FAIL stall_release_pred got=%b exp=1", if_predict_taken); end
    id_no_op = 1; jal_instruction = 1; branch_instruction = 1;
    tick();
    compared++; if ({pc_offset, pc_restore, pc_overload} !== 3'b000) begin mismatched++; $display("FAIL noop_redirect got=%b exp=000", {pc_offset, pc_restore, pc_overload}); end
    compared++; if (branch_count !== 16'd9) begin mismatched++; $display("FAIL noop_no_train got=%0d exp=9", branch_count); end
    idle();
  endtask

  task automatic test_jumps_and_mux();
    id_pc = 32'h0040_0020; id_instruction = {6'h03, 26'h010_0008};
    id_reg_1 = 32'h1234_5678; id_reg_2 = 32'hCAFE_0002; id_sign_extend_result = 32'hFFFF_FFF0;
    id_reg_1_idx = 5'd3; id_reg_2_idx = 5'd7; id_reg_dest_idx = 5'd9; shift_amount = 5'd19;
    jal_instruction = 1;
    #1;
    compared++; if (pc_overload !== 1'b1) begin mismatched++; $display("FAIL jal_overload got=%b exp=1", pc_overload); end
    compared++; if (pc_overload_value !== 32'h0040_0020) begin mismatched++; $display("FAIL jal_target got=%h exp=00400020", pc_overload_value); end
    compared++; if (mux_operand_1 !== 32'h0040_0020) begin mismatched++; $display("FAIL jal_op1 got=%h exp=00400020", mux_operand_1); end
    compared++; if (mux_operand_2 !== 32'd4) begin mismatched++; $display("FAIL jal_op2 got=%h exp=4", mux_operand_2); end
    compared++; if (mux_reg_dest_idx !== 5'd31) begin mismatched++; $display("FAIL jal_dest got=%0d exp=31", mux_reg_dest_idx); end
    compared++; if (mux_reg_1_idx !== 5'd0 || mux_reg_2_idx !== 5'd0) begin mismatched++; $display("FAIL jal_src_idx got=%0d/%0d exp=0/0", mux_reg_1_idx, mux_reg_2_idx); end
    jal_instruction = 0; jr_instruction = 1;
    #1;
    compared++; if (pc_overload_value !== 32'h1234_5678) begin mismatched++; $display("FAIL jr_target got=%h exp=12345678", pc_overload_value); end
    compared++; if (mux_reg_dest_idx !== 5'd0 || mux_reg_1_idx !== 5'd3) begin mismatched++; $display("FAIL jr_idx got=%0d/%0d exp=0/3", mux_reg_dest_idx, mux_reg_1_idx); end
    jr_instruction = 0; shift_instruction = 1; r_type_instruction = 1;
    #1;
    compared++; if (mux_operand_1 !== 32'd19 || mux_reg_1_idx !== 5'd0) begin mismatched++; $display("FAIL shift_op1 got=%h/%0d exp=13/0", mux_operand_1, mux_reg_1_idx); end
    compared++; if (mux_operand_2 !== 32'hCAFE_0002 || mux_reg_2_idx !== 5'd7 || mux_reg_dest_idx !== 5'd9) begin mismatched++; $display("FAIL rtype_mux got=%h/%0d/%0d exp=cafe0002/7/9", mux_operand_2, mux_reg_2_idx, mux_reg_dest_idx); end
    shift_instruction = 0; r_type_instruction = 0; i_type_instruction = 1;
    #1;
    compared++; if (mux_operand_1 !== 32'h1234_5678 || mux_operand_2 !== 32'hFFFF_FFF0) begin mismatched++; $display("FAIL itype_ops got=%h/%h exp=12345678/fffffff0", mux_operand_1, mux_operand_2); end
    compared++; if (mux_reg_dest_idx !== 5'd7 || mux_reg_2_idx !== 5'd0 || mux_reg_1_idx !== 5'd3) begin mismatched++; $display("FAIL itype_idx got=%0d/%0d/%0d exp=7/0/3", mux_reg_dest_idx, mux_reg_2_idx, mux_reg_1_idx); end
    idle();
  endtask

  // 65530 mispredicts bring mispredict_count 5 -> 0xFFFF; one more wraps to 0
  task automatic test_wrap();
    id_pc = 32'h0040_0040; branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 0;
    for (int k = 0; k < 65530; k++) @(posedge clk);
    #1;
    compared++; if (mispredict_count !== 16'hFFFF) begin mismatched++; $display("FAIL wrap_preload got=%h exp=ffff", mispredict_count); end
    tick();
    branch_instruction = 0;
    #1;
    compared++; if (mispredict_count !== 16'h0000) begin mismatched++; $display("FAIL wrap_mispredict got=%h exp=0000", mispredict_count); end
    compared++; if (branch_count !== 16'd4) begin mismatched++; $display("FAIL wrap_branch got=%0d exp=4", branch_count); end
  endtask

  task automatic test_reset_mid_op();
    if_pc = 32'h0040_0010; id_pc = 32'h0040_0010;
    branch_instruction = 1; condition_satisfied = 1; id_predicted_taken = 0;
    @(negedge clk);
    rst = 1;
    #1;
    compared++; if (branch_count !== 16'd0 || if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL rst_async got=%0d/%b exp=0/0", branch_count, if_predict_taken); end
    tick();
    compared++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin mismatched++; $display("FAIL rst_edge_ignored got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    branch_instruction = 0;
    @(negedge clk);
    rst = 0;
    #1;
    compared++; if (if_predict_taken !== 1'b0) begin mismatched++; $display("FAIL rst_bht_reinit got=%b exp=0", if_predict_taken); end
  endtask

  initial begin
    test_reset();
    test_offset();
    test_saturate_restore();
    test_same_index();
    test_stall();
    test_jumps_and_mux();
    test_wrap();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
